// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller: 16 lines x 128 bits, 12-bit byte address,
// single outstanding line fill, saturating hit/miss counters.
module icache_ctrl (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         cpu_req,
  input  logic [11:0]  cpu_addr,
  input  logic         cpu_flush,
  output logic [31:0]  cpu_rdata,
  output logic         cpu_ready,
  output logic         mem_req_out,
  output logic [7:0]   mem_addr_out,
  input  logic [127:0] mem_data_in,
  input  logic         mem_done_in,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
);

  typedef enum logic [1:0] {IDLE, COMPARE, FILL} state_t;

  state_t       state_reg;
  logic [9:0]   addr_reg;        // cpu_addr[11:2]; byte offset is never used
  logic [15:0]  valid_reg;
  logic         from_fill_reg;
  logic [15:0]  hit_count_reg;
  logic [15:0]  miss_count_reg;
  logic         mem_req_reg;
  logic [7:0]   mem_addr_reg;

  logic [127:0] data_mem [16];
  logic [3:0]   tag_mem  [16];
  logic [127:0] line_rd_reg;
  logic [3:0]   tag_rd_reg;

  logic [3:0]   idx;
  logic [3:0]   tag;
  logic         accept;
  logic         fill_done;
  logic         hit;
  logic [31:0]  word_sel;
  logic         unused_bits;

  assign idx         = addr_reg[5:2];
  assign tag         = addr_reg[9:6];
  assign accept      = (state_reg == IDLE) && cpu_req && !cpu_flush;
  assign fill_done   = (state_reg == FILL) && mem_done_in;
  assign hit         = (state_reg == COMPARE) && valid_reg[idx] && (tag_rd_reg == tag);
  assign unused_bits = ^cpu_addr[1:0];

  // Line and tag are read one cycle ahead (at acceptance) so COMPARE sees registered data;
  // a completing fill bypasses the array into the same read registers.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      data_mem[idx] <= mem_data_in;
      tag_mem[idx]  <= tag;
      line_rd_reg   <= mem_data_in;
      tag_rd_reg    <= tag;
    end else if (accept) begin
      line_rd_reg   <= data_mem[cpu_addr[7:4]];
      tag_rd_reg    <= tag_mem[cpu_addr[7:4]];
    end
  end

  always_comb begin
    word_sel = '0;
    case (addr_reg[1:0])
      2'd0:    word_sel = line_rd_reg[31:0];
      2'd1:    word_sel = line_rd_reg[63:32];
      2'd2:    word_sel = line_rd_reg[95:64];
      default: word_sel = line_rd_reg[127:96];
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      addr_reg       <= '0;
      valid_reg      <= '0;
      from_fill_reg  <= 1'b0;
      hit_count_reg  <= '0;
      miss_count_reg <= '0;
      mem_req_reg    <= 1'b0;
      mem_addr_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cpu_flush) begin
            valid_reg <= '0;
          end else if (cpu_req) begin
            addr_reg      <= cpu_addr[11:2];
            from_fill_reg <= 1'b0;
            state_reg     <= COMPARE;
          end
        end
        COMPARE: begin
          if (hit) begin
            // The hit that completes a refill belongs to the miss already counted.
            if (!from_fill_reg && hit_count_reg != 16'hFFFF)
              hit_count_reg <= hit_count_reg + 16'd1;
            state_reg <= IDLE;
          end else begin
            if (miss_count_reg != 16'hFFFF)
              miss_count_reg <= miss_count_reg + 16'd1;
            mem_req_reg  <= 1'b1;
            mem_addr_reg <= addr_reg[9:2];
            state_reg    <= FILL;
          end
        end
        FILL: begin
          if (mem_done_in) begin
            valid_reg[idx] <= 1'b1;
            from_fill_reg  <= 1'b1;
            mem_req_reg    <= 1'b0;
            mem_addr_reg   <= '0;
            state_reg      <= COMPARE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign cpu_ready    = hit;
  assign cpu_rdata    = hit ? word_sel : 32'd0;
  assign mem_req_out  = mem_req_reg;
  assign mem_addr_out = mem_addr_reg;
  assign hit_count    = hit_count_reg;
  assign miss_count   = miss_count_reg;

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl: scoreboard of expected fetch words, latency and
// counter checks, flush, eviction, reset during fill and hit-counter saturation.
module tb_icache_ctrl;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         cpu_req;
  logic [11:0]  cpu_addr;
  logic         cpu_flush;
  logic [31:0]  cpu_rdata;
  logic         cpu_ready;
  logic         mem_req_out;
  logic [7:0]   mem_addr_out;
  logic [127:0] mem_data_in;
  logic         mem_done_in;
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_hit  = 0;
  int exp_miss = 0;
  logic [31:0] sb_q[$];

  icache_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cpu_req     (cpu_req),
    .cpu_addr    (cpu_addr),
    .cpu_flush   (cpu_flush),
    .cpu_rdata   (cpu_rdata),
    .cpu_ready   (cpu_ready),
    .mem_req_out (mem_req_out),
    .mem_addr_out(mem_addr_out),
    .mem_data_in (mem_data_in),
    .mem_done_in (mem_done_in),
    .hit_count   (hit_count),
    .miss_count  (miss_count)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] line_data(input logic [7:0] ln);
    logic [127:0] d;
    d = '0;
    if (ln == 8'h12) d = 128'h44443333_22221111_DEADBEEF_00000000;
    else for (int w = 0; w < 4; w++) d[32*w +: 32] = {8'hC0, ln, 8'h5A, 8'(w)};
    return d;
  endfunction

  function automatic logic [31:0] word_of(input logic [11:0] a);
    logic [127:0] d;
    int w;
    d = line_data(a[11:4]);
    w = int'(a[3:2]);
    return d[32*w +: 32];
  endfunction

  function automatic logic [31:0] sat(input int x);
    return (x > 65535) ? 32'd65535 : 32'(x);
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_counts(input string tag);
    check32({tag, "_hits"}, 32'(hit_count), sat(exp_hit));
    check32({tag, "_misses"}, 32'(miss_count), sat(exp_miss));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One fetch: drive the request, answer fills after 'waits' idle FILL cycles, measure latency.
  task automatic access(input logic [11:0] addr, input int waits, input bit exp_is_hit,
                        input string tag);
    int lat = 0;
    int wcnt = 0;
    bit got = 1'b0;
    bit saw_req = 1'b0;
    logic [127:0] line;
    line = line_data(addr[11:4]);
    sb_q.push_back(word_of(addr));
    cpu_addr = addr;
    cpu_req  = 1'b1;
    step();
    cpu_req  = 1'b0;
    cpu_addr = 12'($urandom);
    lat = 1;
    while (!got && lat < 40) begin
      if (cpu_ready === 1'b1) begin
        got = 1'b1;
      end else begin
        if (mem_req_out === 1'b1) begin
          saw_req = 1'b1;
          check32({tag, "_mem_addr"}, 32'(mem_addr_out), 32'(addr[11:4]));
          if (wcnt == waits) begin
            mem_done_in = 1'b1;
            mem_data_in = line;
          end else begin
            wcnt++;
          end
        end
        step();
        mem_done_in = 1'b0;
        mem_data_in = {$urandom, $urandom, $urandom, $urandom};
        lat++;
      end
    end
    check32({tag, "_latency"}, 32'(lat), exp_is_hit ? 32'd1 : 32'(3 + waits));
    check32({tag, "_mem_req_seen"}, 32'(saw_req), exp_is_hit ? 32'd0 : 32'd1);
    if (exp_is_hit) exp_hit++;
    else exp_miss++;
    step();
    check32({tag, "_ready_drops"}, 32'(cpu_ready), 32'd0);
  endtask

  // Scoreboard: every cpu_ready strobe must match the oldest outstanding expected word.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && cpu_ready === 1'b1) begin
      n_checks++;
      assert (sb_q.size() != 0) n_pass++;
      else $error("FAIL sb_unexpected_ready: observed ready with rdata %h expected no ready", cpu_rdata);
      if (sb_q.size() != 0) check32("sb_rdata", cpu_rdata, sb_q.pop_front());
    end
  end

  initial begin
    reset_n     = 1'b0;
    cpu_req     = 1'b0;
    cpu_addr    = '0;
    cpu_flush   = 1'b0;
    mem_done_in = 1'b0;
    mem_data_in = '0;
    step();
    check32("rst_ready", 32'(cpu_ready), 32'd0);
    check32("rst_rdata", cpu_rdata, 32'd0);
    check32("rst_mem_req", 32'(mem_req_out), 32'd0);
    check32("rst_mem_addr", 32'(mem_addr_out), 32'd0);
    check_counts("rst");
    step();
    reset_n = 1'b1;

    // Cold miss, then hits on the same line
    access(12'h124, 0, 1'b0, "cold_miss");
    check_counts("cold_miss");
    access(12'h128, 0, 1'b1, "hit_w2");
    check_counts("hit_w2");
    access(12'h12C, 0, 1'b1, "hit_w3");
    access(12'h138, 0, 1'b0, "idx3_miss");

    // Conflict eviction on index 2; index 3 must survive
    access(12'h324, 0, 1'b0, "evict_fill");
    access(12'h124, 0, 1'b0, "evicted_miss");
    check_counts("evict");
    access(12'h134, 0, 1'b1, "idx3_kept");

    // Flush with a simultaneous request: request dropped, everything invalid
    cpu_flush = 1'b1;
    cpu_req   = 1'b1;
    cpu_addr  = 12'h124;
    step();
    cpu_flush = 1'b0;
    cpu_req   = 1'b0;
    check32("flush_no_ready", 32'(cpu_ready), 32'd0);
    step();
    check32("flush_no_fill", 32'(mem_req_out), 32'd0);
    check_counts("flush");
    access(12'h124, 2, 1'b0, "post_flush_miss");
    access(12'h138, 0, 1'b0, "post_flush_idx3");

    // Wait states, then reset in the middle of the fill
    cpu_addr = 12'h456;
    cpu_req  = 1'b1;
    step();
    cpu_req  = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      check32("wait_mem_req", 32'(mem_req_out), 32'd1);
      check32("wait_mem_addr", 32'(mem_addr_out), 32'h45);
      step();
    end
    mem_done_in = 1'b1;
    mem_data_in = line_data(8'h45);
    #2;
    reset_n = 1'b0;
    #1;
    check32("rst_fill_mem_req", 32'(mem_req_out), 32'd0);
    check32("rst_fill_mem_addr", 32'(mem_addr_out), 32'd0);
    exp_hit  = 0;
    exp_miss = 0;
    check_counts("rst_fill");
    step();
    mem_done_in = 1'b0;
    step();
    reset_n = 1'b1;
    access(12'h456, 0, 1'b0, "after_rst_miss");
    access(12'h45C, 0, 1'b1, "after_rst_hit");
    check_counts("after_rst");

    // Hit-counter saturation
    for (int i = 0; i < 65537; i++) begin
      sb_q.push_back(word_of(12'h45C));
      cpu_addr = 12'h45C;
      cpu_req  = 1'b1;
      step();
      cpu_req  = 1'b0;
      step();
      exp_hit++;
    end
    check_counts("saturate");
    check32("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
